// File: rtl/div_and_reflect_divisor_as_registered_out_pkg.sv
`default_nettype none
// ============================================================================
// Module   : div_reflect_pkg
// Purpose  : Shared types and constants for the sequential signed divider
//            that reflects its divisor as a registered output.
// Contents : state_t FSM encoding, default operand widths, quotient
//            saturation bounds for the default quotient width.
// Revision : 1.0 - initial release
// ============================================================================
package div_reflect_pkg;

   localparam int DIV_A_WIDTH = 20;                          // quotient width
   localparam int DIV_B_WIDTH = 18;                          // divisor/remainder width
   localparam int DIV_P_WIDTH = DIV_A_WIDTH + DIV_B_WIDTH;   // dividend width

   // Signed quotient range for the default quotient width
   localparam int DIV_Q_MAX = (1 << (DIV_A_WIDTH - 1)) - 1;
   localparam int DIV_Q_MIN = -(1 << (DIV_A_WIDTH - 1));

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      SIGN = 2'd2
   } state_t;

endpackage : div_reflect_pkg
`default_nettype wire

// File: rtl/div_and_reflect_divisor_as_registered_out_if.sv
`default_nettype none
// ============================================================================
// Module   : div_and_reflect_divisor_as_registered_out_if
// Purpose  : Request/result bundle between a requester and the divider.
// Signals  : start, P, B         - request (requester -> divider)
//            busy, done, A, R,
//            DlyB_o, ovf, dbz    - status and results (divider -> requester)
// Modports : master (requester), slave (divider)
// Revision : 1.0 - initial release
// ============================================================================
interface div_and_reflect_divisor_as_registered_out_if
#(
   parameter int A_WIDTH = div_reflect_pkg::DIV_A_WIDTH,
   parameter int B_WIDTH = div_reflect_pkg::DIV_B_WIDTH
);
   localparam int P_WIDTH = A_WIDTH + B_WIDTH;

   logic                      start;
   logic signed [P_WIDTH-1:0] P;
   logic signed [B_WIDTH-1:0] B;
   logic                      busy;
   logic                      done;
   logic signed [A_WIDTH-1:0] A;
   logic signed [B_WIDTH-1:0] R;
   logic signed [B_WIDTH-1:0] DlyB_o;
   logic                      ovf;
   logic                      dbz;

   modport master (
      output start, P, B,
      input  busy, done, A, R, DlyB_o, ovf, dbz
   );

   modport slave (
      input  start, P, B,
      output busy, done, A, R, DlyB_o, ovf, dbz
   );

endinterface : div_and_reflect_divisor_as_registered_out_if
`default_nettype wire

// File: rtl/div_and_reflect_divisor_as_registered_out_step.sv
`default_nettype none
// ============================================================================
// Module   : div_restoring_step
// Purpose  : One restoring-division step on unsigned magnitudes.
// Ports    : rem_in  [B_WIDTH] partial remainder (always < divisor)
//            bit_in            next dividend bit, MSB first
//            divisor [B_WIDTH] |B|
//            rem_out [B_WIDTH] new partial remainder
//            q_bit             quotient bit for this step
// Revision : 1.0 - initial release
// ============================================================================
module div_restoring_step
   import div_reflect_pkg::*;
#(
   parameter int B_WIDTH = DIV_B_WIDTH
)
(
   input  logic [B_WIDTH-1:0] rem_in,
   input  logic               bit_in,
   input  logic [B_WIDTH-1:0] divisor,
   output logic [B_WIDTH-1:0] rem_out,
   output logic               q_bit
);

   logic [B_WIDTH:0]   trial;
   logic [B_WIDTH-1:0] diff;

   // rem_in < divisor, so the shifted trial needs one extra bit, but the
   // difference after a successful subtract always fits back in B_WIDTH.
   always_comb begin
      trial   = {rem_in, bit_in};
      q_bit   = (trial >= {1'b0, divisor});
      diff    = trial[B_WIDTH-1:0] - divisor;
      rem_out = q_bit ? diff : trial[B_WIDTH-1:0];
   end

endmodule : div_restoring_step
`default_nettype wire

// File: rtl/div_and_reflect_divisor_as_registered_out.sv
`default_nettype none
// ============================================================================
// Module   : div_and_reflect_divisor_as_registered_out
// Purpose  : Sequential signed divider A = P / B (truncated toward zero) with
//            remainder R, quotient saturation and divide-by-zero flagging.
//            The accepted divisor is reflected on DlyB_o.
// Ports    : clk   - rising-edge clock
//            reset - synchronous, active-low reset
//            bus   - slave side of the request/result interface
// Revision : 1.0 - initial release
// ============================================================================
module div_and_reflect_divisor_as_registered_out
   import div_reflect_pkg::*;
#(
   parameter int A_WIDTH = DIV_A_WIDTH,
   parameter int B_WIDTH = DIV_B_WIDTH
)
(
   input  logic clk,
   input  logic reset,
   div_and_reflect_divisor_as_registered_out_if.slave bus
);

   localparam int P_WIDTH = A_WIDTH + B_WIDTH;

   // Quotient magnitude limits for each result sign
   localparam logic [P_WIDTH-1:0] POS_LIM = P_WIDTH'((longint'(1) << (A_WIDTH - 1)) - 1);
   localparam logic [P_WIDTH-1:0] NEG_LIM = P_WIDTH'(longint'(1) << (A_WIDTH - 1));
   localparam logic [A_WIDTH-1:0] A_MAX   = {1'b0, {(A_WIDTH-1){1'b1}}};
   localparam logic [A_WIDTH-1:0] A_MIN   = {1'b1, {(A_WIDTH-1){1'b0}}};

   state_t state, state_nxt;

   logic [P_WIDTH-1:0] p_mag;     // dividend magnitude, shifted left each step
   logic [P_WIDTH-1:0] q_mag;     // quotient magnitude, bits shifted in MSB first
   logic [B_WIDTH-1:0] b_mag;
   logic [B_WIDTH-1:0] rem;
   logic               neg_p;
   logic               neg_q;
   logic               dbz_pend;
   logic [5:0]         cnt;

   logic [P_WIDTH-1:0] p_abs;
   logic [B_WIDTH-1:0] b_abs;
   logic [B_WIDTH-1:0] step_rem;
   logic               step_q;
   logic               ovf_pos;
   logic               ovf_neg;
   logic [A_WIDTH-1:0] a_val;
   logic [B_WIDTH-1:0] r_val;

   logic [A_WIDTH-1:0] a_q;
   logic [B_WIDTH-1:0] r_q;
   logic [B_WIDTH-1:0] dlyb_q;
   logic               ovf_q;
   logic               dbz_q;
   logic               done_q;

   div_restoring_step #(.B_WIDTH(B_WIDTH)) u_step (
      .rem_in  (rem),
      .bit_in  (p_mag[P_WIDTH-1]),
      .divisor (b_mag),
      .rem_out (step_rem),
      .q_bit   (step_q)
   );

   // Two's-complement negation of the most negative value yields exactly
   // 2^(W-1), which the unsigned magnitude vectors represent correctly.
   always_comb begin
      p_abs = bus.P[P_WIDTH-1] ? -bus.P : bus.P;
      b_abs = bus.B[B_WIDTH-1] ? -bus.B : bus.B;
   end

   // Saturation is decided on the magnitude so that 2^(P_WIDTH-1) (from
   // -2^37 / -1) never has to be held in a signed vector.
   always_comb begin
      ovf_pos = !neg_q && (q_mag > POS_LIM);
      ovf_neg =  neg_q && (q_mag > NEG_LIM);
      a_val   = neg_q ? -q_mag[A_WIDTH-1:0] : q_mag[A_WIDTH-1:0];
      r_val   = neg_p ? -rem : rem;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (bus.start) begin
               state_nxt = (bus.B == '0) ? SIGN : CALC;
            end
         end
         CALC: begin
            if (cnt == '0) begin
               state_nxt = SIGN;
            end
         end
         SIGN: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         p_mag    <= '0;
         q_mag    <= '0;
         b_mag    <= '0;
         rem      <= '0;
         neg_p    <= 1'b0;
         neg_q    <= 1'b0;
         dbz_pend <= 1'b0;
         cnt      <= '0;
         a_q      <= '0;
         r_q      <= '0;
         dlyb_q   <= '0;
         ovf_q    <= 1'b0;
         dbz_q    <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  p_mag    <= p_abs;
                  b_mag    <= b_abs;
                  neg_p    <= bus.P[P_WIDTH-1];
                  neg_q    <= bus.P[P_WIDTH-1] ^ bus.B[B_WIDTH-1];
                  dlyb_q   <= bus.B;
                  dbz_pend <= (bus.B == '0);
                  rem      <= '0;
                  q_mag    <= '0;
                  cnt      <= 6'(P_WIDTH - 1);
               end
            end
            CALC: begin
               rem   <= step_rem;
               q_mag <= {q_mag[P_WIDTH-2:0], step_q};
               p_mag <= {p_mag[P_WIDTH-2:0], 1'b0};
               cnt   <= cnt - 6'd1;
            end
            SIGN: begin
               done_q <= 1'b1;
               if (dbz_pend) begin
                  a_q   <= '0;
                  r_q   <= '0;
                  ovf_q <= 1'b0;
                  dbz_q <= 1'b1;
               end else if (ovf_pos || ovf_neg) begin
                  a_q   <= ovf_pos ? A_MAX : A_MIN;
                  r_q   <= '0;
                  ovf_q <= 1'b1;
                  dbz_q <= 1'b0;
               end else begin
                  a_q   <= a_val;
                  r_q   <= r_val;
                  ovf_q <= 1'b0;
                  dbz_q <= 1'b0;
               end
            end
            default: begin
               done_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.busy   = (state != IDLE);
   assign bus.done   = done_q;
   assign bus.A      = a_q;
   assign bus.R      = r_q;
   assign bus.DlyB_o = dlyb_q;
   assign bus.ovf    = ovf_q;
   assign bus.dbz    = dbz_q;

endmodule : div_and_reflect_divisor_as_registered_out
`default_nettype wire
